uart_io_fifo: RTL and testbench

- Next-generation UART I/O block for the RS232-C path.
- Runs entirely on the single RSClk domain, with a programmable baud-tick enable instead of gated bit clocks.
- Parametrised data width, per-direction FIFOs, optional parity, sticky error flags.
- Keeps the loopback/bypass pin test modes; sits between the transaction layer (parallel side) and the xipRXD*/xopTXD* pads.

---
 rtl/uart_io_fifo.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_uart_io_fifo.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_fifo.sv
// UART I/O block: baud tick, TX/RX FIFOs, framer/deframer, pad test-mode mux.
// Single RSClk domain; serial timing comes from a 16x oversample tick enable.

module uart_io_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) &&
              (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop && !empty;
    // a pop frees the slot, so a push on a full FIFO is still accepted
    do_push = push && (!full || do_pop);
    wr_d    = wr_q + {{AW{1'b0}}, do_push};
    rd_d    = rd_q + {{AW{1'b0}}, do_pop};
    rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_q[AW-1:0]] <= wdata;
  end
endmodule

module uart_io_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic              RSClk,
  input  logic              Reset_n,
  input  logic [1:0]        TestMode,
  input  logic [DIV_W-1:0]  BaudDiv,
  input  logic              ParityEn,
  input  logic              ParityOdd,
  input  logic              TxWrite,
  input  logic [DATA_W-1:0] TxData,
  output logic              TxFull,
  output logic              TxIdle,
  input  logic              RxRead,
  output logic [DATA_W-1:0] RxData,
  output logic              RxEmpty,
  input  logic              ErrClear,
  output logic              RxFramingErr,
  output logic              RxParityErr,
  output logic              RxOverrun,
  input  logic              xipRXD1,
  input  logic              xipRXD2,
  output logic              xopTXD1
);
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ONE = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } st_e;

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick;

  st_e               tx_st_q, tx_st_d;
  logic [3:0]        tx_tcnt_q, tx_tcnt_d;
  logic [BW-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              tx_par_q, tx_par_d;
  logic              tx_line_q, tx_line_d;
  logic              tx_pop, tx_load;
  logic              tx_first, tx_last;
  logic              tx_empty;
  logic [DATA_W-1:0] tx_head;

  logic              rx_src;
  logic              rx_s1_q, rx_s2_q, rx_s3_q;
  st_e               rx_st_q, rx_st_d;
  logic [3:0]        rx_tcnt_q, rx_tcnt_d;
  logic [BW-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic              rx_push, rx_full;
  logic              rx_mid, rx_fall;
  logic              fe_set, pe_set, ov_set;
  logic              fe_q, fe_d;
  logic              pe_q, pe_d;
  logic              ov_q, ov_d;

  // divisor is latched at each wrap so a BaudDiv change never truncates a period
  always_comb begin
    tick  = (cnt_q == div_q);
    cnt_d = tick ? '0 : cnt_q + DIV_ONE;
    div_d = tick ? BaudDiv : div_q;
  end

  uart_io_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (RSClk),
    .rst_n (Reset_n),
    .push  (TxWrite),
    .pop   (tx_pop),
    .wdata (TxData),
    .rdata (tx_head),
    .full  (TxFull),
    .empty (tx_empty)
  );

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_tcnt_d = tx_tcnt_q;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    tx_par_d  = tx_par_q;
    tx_line_d = tx_line_q;
    tx_pop    = 1'b0;
    tx_load   = 1'b0;
    tx_first  = tick && (tx_tcnt_q == 4'd0);
    tx_last   = tick && (tx_tcnt_q == 4'd15);
    if (tick && tx_st_q != ST_IDLE)
      tx_tcnt_d = tx_tcnt_q + 4'd1;
    case (tx_st_q)
      ST_IDLE: tx_load = !tx_empty;
      ST_START: begin
        if (tx_first) tx_line_d = 1'b0;
        if (tx_last) begin
          tx_st_d  = ST_DATA;
          tx_bit_d = '0;
        end
      end
      ST_DATA: begin
        if (tx_first) tx_line_d = tx_sh_q[0];
        if (tx_last) begin
          tx_sh_d = tx_sh_q >> 1;
          if (tx_bit_q == LAST_BIT)
            tx_st_d = ParityEn ? ST_PARITY : ST_STOP;
          else
            tx_bit_d = tx_bit_q + BIT_ONE;
        end
      end
      ST_PARITY: begin
        if (tx_first) tx_line_d = tx_par_q;
        if (tx_last) tx_st_d = ST_STOP;
      end
      ST_STOP: begin
        if (tx_first) tx_line_d = 1'b1;
        if (tx_last) begin
          tx_st_d = ST_IDLE;
          // chain straight into the next frame: no idle gap
          tx_load = !tx_empty;
        end
      end
      default: tx_st_d = ST_IDLE;
    endcase
    if (tx_load) begin
      tx_pop    = 1'b1;
      tx_sh_d   = tx_head;
      tx_par_d  = (^tx_head) ^ ParityOdd;
      tx_st_d   = ST_START;
      tx_tcnt_d = '0;
    end
  end

  assign TxIdle = (tx_st_q == ST_IDLE) && tx_empty;

  always_comb begin
    unique case (TestMode)
      2'b01:   xopTXD1 = 1'b1;
      2'b10:   xopTXD1 = xipRXD2;
      default: xopTXD1 = tx_line_q;
    endcase
    rx_src = (TestMode == 2'b01) ? tx_line_q : xipRXD1;
  end

  uart_io_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (RSClk),
    .rst_n (Reset_n),
    .push  (rx_push),
    .pop   (RxRead),
    .wdata (rx_sh_q),
    .rdata (RxData),
    .full  (rx_full),
    .empty (RxEmpty)
  );

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_tcnt_d = rx_tcnt_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_push   = 1'b0;
    fe_set    = 1'b0;
    pe_set    = 1'b0;
    rx_fall   = rx_s3_q && !rx_s2_q;
    rx_mid    = tick && (rx_tcnt_q == 4'd15);
    if (tick && rx_st_q != ST_IDLE)
      rx_tcnt_d = rx_tcnt_q + 4'd1;
    case (rx_st_q)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_st_d   = ST_START;
          rx_tcnt_d = '0;
        end
      end
      ST_START: begin
        // half-bit check, then realign the phase so later samples hit mid-bit
        if (tick && rx_tcnt_q == 4'd7) begin
          rx_tcnt_d = '0;
          rx_bit_d  = '0;
          rx_st_d   = rx_s2_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_mid) begin
          rx_sh_d = {rx_s2_q, rx_sh_q[DATA_W-1:1]};
          if (rx_bit_q == LAST_BIT)
            rx_st_d = ParityEn ? ST_PARITY : ST_STOP;
          else
            rx_bit_d = rx_bit_q + BIT_ONE;
        end
      end
      ST_PARITY: begin
        if (rx_mid) begin
          pe_set  = rx_s2_q != ((^rx_sh_q) ^ ParityOdd);
          rx_st_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (rx_mid) begin
          fe_set  = !rx_s2_q;
          rx_push = 1'b1;
          rx_st_d = ST_IDLE;
        end
      end
      default: rx_st_d = ST_IDLE;
    endcase
    ov_set = rx_push && rx_full && !RxRead;
    fe_d   = (fe_q && !ErrClear) || fe_set;
    pe_d   = (pe_q && !ErrClear) || pe_set;
    ov_d   = (ov_q && !ErrClear) || ov_set;
  end

  assign RxFramingErr = fe_q;
  assign RxParityErr  = pe_q;
  assign RxOverrun    = ov_q;

  always_ff @(posedge RSClk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q     <= '0;
      div_q     <= '0;
      tx_st_q   <= ST_IDLE;
      tx_tcnt_q <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_par_q  <= 1'b0;
      tx_line_q <= 1'b1;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_s3_q   <= 1'b1;
      rx_st_q   <= ST_IDLE;
      rx_tcnt_q <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      tx_st_q   <= tx_st_d;
      tx_tcnt_q <= tx_tcnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_par_q  <= tx_par_d;
      tx_line_q <= tx_line_d;
      rx_s1_q   <= rx_src;
      rx_s2_q   <= rx_s1_q;
      rx_s3_q   <= rx_s2_q;
      rx_st_q   <= rx_st_d;
      rx_tcnt_q <= rx_tcnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      ov_q      <= ov_d;
    end
  end
endmodule

// File: tb/tb_uart_io_fifo.sv
// Randomised bench for uart_io_fifo: serial frames built from the frame rules,
// expected RX words kept in a queue, pad mux checked every cycle.

module tb_uart_io_fifo;
  logic        RSClk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [1:0]  TestMode = 2'b00;
  logic [15:0] BaudDiv = 16'd0;
  logic        ParityEn = 1'b0;
  logic        ParityOdd = 1'b0;
  logic        TxWrite = 1'b0;
  logic [7:0]  TxData = 8'h00;
  logic        TxFull, TxIdle;
  logic        RxRead = 1'b0;
  logic [7:0]  RxData;
  logic        RxEmpty;
  logic        ErrClear = 1'b0;
  logic        RxFramingErr, RxParityErr, RxOverrun;
  logic        xipRXD1 = 1'b1;
  logic        xipRXD2 = 1'b1;
  logic        xopTXD1;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  uart_io_fifo #(.DATA_W(8), .FIFO_DEPTH(8), .DIV_W(16)) dut (
    .RSClk(RSClk), .Reset_n(Reset_n), .TestMode(TestMode),
    .BaudDiv(BaudDiv), .ParityEn(ParityEn), .ParityOdd(ParityOdd),
    .TxWrite(TxWrite), .TxData(TxData), .TxFull(TxFull),
    .TxIdle(TxIdle), .RxRead(RxRead), .RxData(RxData),
    .RxEmpty(RxEmpty), .ErrClear(ErrClear),
    .RxFramingErr(RxFramingErr), .RxParityErr(RxParityErr),
    .RxOverrun(RxOverrun), .xipRXD1(xipRXD1), .xipRXD2(xipRXD2),
    .xopTXD1(xopTXD1)
  );

  always #5 RSClk = ~RSClk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // pad mux model: loopback forces idle level, bypass mirrors xipRXD2
  always @(negedge RSClk) begin
    if (Reset_n) begin
      if (TestMode == 2'b01) chk("pad_loopback", xopTXD1, 1);
      else if (TestMode == 2'b10) chk("pad_bypass", xopTXD1, xipRXD2);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge RSClk);
    #1;
  endtask

  task automatic tx_write(input logic [7:0] d);
    TxData = d;
    TxWrite = 1'b1;
    cyc(1);
    TxWrite = 1'b0;
  endtask

  task automatic err_clear();
    ErrClear = 1'b1;
    cyc(1);
    ErrClear = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pen,
                            input bit pbit, input bit stopb, input int bc);
    xipRXD1 = 1'b0;
    cyc(bc);
    for (int i = 0; i < 8; i++) begin
      xipRXD1 = d[i];
      cyc(bc);
    end
    if (pen) begin
      xipRXD1 = pbit;
      cyc(bc);
    end
    xipRXD1 = stopb;
    cyc(bc);
    xipRXD1 = 1'b1;
    cyc(2);
  endtask

  task automatic rx_pop(input string nm);
    int n;
    logic [7:0] e;
    n = 0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    while (RxEmpty && n < 3000) begin
      cyc(1);
      n++;
    end
    if (RxEmpty) chk({nm, "_timeout"}, 1, 0);
    else begin
      chk(nm, RxData, e);
      RxRead = 1'b1;
      cyc(1);
      RxRead = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int bad;
    logic [7:0] d;
    bit odd;
    bit a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    cyc(2);
    chk("rst_txd", xopTXD1, 1);
    chk("rst_txfull", TxFull, 0);
    chk("rst_txidle", TxIdle, 1);
    chk("rst_rxempty", RxEmpty, 1);
    chk("rst_rxdata", RxData, 0);
    chk("rst_errs", {RxFramingErr, RxParityErr, RxOverrun}, 0);
    Reset_n = 1'b1;
    cyc(5);

    // single 0xA5 frame at one tick per clock
    tx_write(8'hA5);
    lat = 0;
    while (xopTXD1 && lat < 5) begin
      cyc(1);
      lat++;
    end
    chk("tx_fall_lat", (lat >= 1 && lat <= 2), 1);
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < 16; c++) begin
        if (xopTXD1 !== a5_bits[b]) bad++;
        if (b == 9 && c == 6) chk("txidle_busy", TxIdle, 0);
        cyc(1);
      end
      chk($sformatf("tx_a5_bit%0d_badcycles", b), bad, 0);
    end
    chk("txidle_done", TxIdle, 1);
    chk("txd_idle_high", xopTXD1, 1);

    // loopback with even parity, back-to-back frames
    TestMode = 2'b01;
    ParityEn = 1'b1;
    ParityOdd = 1'b0;
    BaudDiv = 16'd3;
    cyc(10);
    tx_write(8'h00); exp_q.push_back(8'h00);
    tx_write(8'hFF); exp_q.push_back(8'hFF);
    tx_write(8'h3C); exp_q.push_back(8'h3C);
    for (int k = 0; k < 3; k++) rx_pop("loop_word");
    chk("loop_errs", {RxFramingErr, RxParityErr, RxOverrun}, 0);
    ParityOdd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      tx_write(d);
    end
    for (int k = 0; k < 4; k++) rx_pop("loop_rand_word");
    chk("loop_odd_errs", {RxFramingErr, RxParityErr, RxOverrun}, 0);
    cyc(20);

    // framing error on the external pad
    TestMode = 2'b00;
    ParityEn = 1'b0;
    BaudDiv = 16'd1;
    cyc(10);
    send_frame(8'h55, 0, 0, 0, 32);
    exp_q.push_back(8'h55);
    chk("fe_set", RxFramingErr, 1);
    chk("fe_others", {RxParityErr, RxOverrun}, 0);
    rx_pop("fe_word");
    err_clear();
    chk("fe_cleared", RxFramingErr, 0);

    // nine frames into an eight-deep FIFO
    for (int k = 0; k < 9; k++) begin
      d = 8'($urandom);
      if (k < 8) exp_q.push_back(d);
      send_frame(d, 0, 0, 1, 32);
      if (k == 7) begin
        chk("ov_before", RxOverrun, 0);
        chk("ov_notempty", RxEmpty, 0);
      end
    end
    chk("ov_set", RxOverrun, 1);
    for (int k = 0; k < 8; k++) rx_pop("ov_drain");
    chk("ov_drained_empty", RxEmpty, 1);
    err_clear();
    chk("ov_cleared", RxOverrun, 0);

    // start-bit glitch rejection, then parity error
    BaudDiv = 16'd0;
    cyc(5);
    xipRXD1 = 1'b0;
    cyc(3);
    xipRXD1 = 1'b1;
    cyc(40);
    chk("glitch_no_word", RxEmpty, 1);
    d = 8'($urandom);
    exp_q.push_back(d);
    send_frame(d, 0, 0, 1, 16);
    rx_pop("after_glitch_word");
    ParityEn = 1'b1;
    odd = 1'($urandom);
    ParityOdd = odd;
    d = 8'($urandom);
    exp_q.push_back(d);
    send_frame(d, 1, ~((^d) ^ odd), 1, 16);
    chk("pe_set", RxParityErr, 1);
    rx_pop("pe_word");
    err_clear();
    chk("pe_cleared", RxParityErr, 0);
    d = 8'($urandom);
    exp_q.push_back(d);
    send_frame(d, 1, (^d) ^ odd, 1, 16);
    rx_pop("pe_good_word");
    chk("pe_good_noerr", RxParityErr, 0);

    // TX FIFO fill while a frame is in flight
    TestMode = 2'b01;
    ParityEn = 1'b0;
    cyc(5);
    d = 8'($urandom);
    exp_q.push_back(d);
    tx_write(d);
    cyc(3);
    for (int k = 0; k < 9; k++) begin
      d = 8'($urandom);
      if (k < 8) exp_q.push_back(d);
      tx_write(d);
    end
    chk("txfull_set", TxFull, 1);
    for (int k = 0; k < 9; k++) rx_pop("txfill_word");
    cyc(400);
    chk("txfill_no_extra", RxEmpty, 1);
    chk("txfill_idle", TxIdle, 1);
    chk("txfill_notfull", TxFull, 0);

    // bypass pad path
    TestMode = 2'b10;
    for (int k = 0; k < 20; k++) begin
      xipRXD2 = 1'($urandom);
      cyc(1);
    end
    xipRXD2 = 1'b1;

    // asynchronous reset in the middle of a frame
    TestMode = 2'b01;
    tx_write(8'($urandom));
    lat = 0;
    while (RxEmpty && lat < 3000) begin
      cyc(1);
      lat++;
    end
    chk("pre_rst_rx_word", RxEmpty, 0);
    TestMode = 2'b00;
    tx_write(8'h00);
    cyc(30);
    chk("pre_rst_txd_low", xopTXD1, 0);
    chk("pre_rst_busy", TxIdle, 0);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_rst_txd", xopTXD1, 1);
    chk("async_rst_idle", TxIdle, 1);
    chk("async_rst_rxempty", RxEmpty, 1);
    chk("async_rst_rxdata", RxData, 0);
    cyc(2);
    Reset_n = 1'b1;
    cyc(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
